// File: rtl/eth_idma_meta_mux.sv
// Merges NumPorts iDMA meta-word sources onto one shared meta channel through a circular FIFO.
// Latency: a word accepted at edge N is at the FIFO head (meta_o/valid_o) in cycle N+1; no bypass.
// Backpressure: ready_o is one-hot on the granted port, all low when the FIFO is full and not popping.
// Optional AXI-Stream packet locking is compiled in with `define ETH_IDMA_META_MUX_LOCK_EN.
module eth_idma_meta_mux #(
  parameter int unsigned NumPorts     = 2,
  parameter int unsigned MetaWidth    = 128,
  parameter int unsigned FifoDepth    = 4,
  parameter int unsigned PortIdxWidth = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NumPorts*MetaWidth-1:0]     meta_i,
  input  logic [NumPorts-1:0]               proto_i,
  input  logic [NumPorts-1:0]               last_i,
  input  logic [NumPorts-1:0]               valid_i,
  output logic [NumPorts-1:0]               ready_o,
  output logic [MetaWidth-1:0]              meta_o,
  output logic                              proto_o,
  output logic                              last_o,
  output logic [PortIdxWidth-1:0]           port_o,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [$clog2(FifoDepth+1)-1:0]    count_o
);

  localparam int unsigned PtrWidth = $clog2(FifoDepth);
  localparam int unsigned CntWidth = $clog2(FifoDepth + 1);

  // Per-port view of the packed input word bus.
  logic [MetaWidth-1:0] meta_arr [NumPorts];

  for (genvar k = 0; k < NumPorts; k++) begin : g_unpack
    assign meta_arr[k] = meta_i[k*MetaWidth +: MetaWidth];
  end

  // FIFO storage and pointers.
  logic [MetaWidth-1:0]    meta_mem_q  [FifoDepth];
  logic [MetaWidth-1:0]    meta_mem_d  [FifoDepth];
  logic [PortIdxWidth-1:0] port_mem_q  [FifoDepth];
  logic [PortIdxWidth-1:0] port_mem_d  [FifoDepth];
  logic [FifoDepth-1:0]    proto_mem_q, proto_mem_d;
  logic [FifoDepth-1:0]    last_mem_q,  last_mem_d;
  logic [PtrWidth-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrWidth-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CntWidth-1:0]     count_q,  count_d;

  // Arbiter state.
  logic [PortIdxWidth-1:0] rr_q, rr_d;
`ifdef ETH_IDMA_META_MUX_LOCK_EN
  logic                    lock_q, lock_d;
  logic [PortIdxWidth-1:0] lock_port_q, lock_port_d;
`endif

  // Arbitration scratch.
  logic                    full;
  logic                    pop;
  logic                    can_push;
  logic                    push;
  logic                    gnt_vld;
  logic [PortIdxWidth-1:0] gnt_idx;
  logic [PortIdxWidth-1:0] gnt_nxt;
  logic [PortIdxWidth:0]   cand;
  logic [PortIdxWidth-1:0] cidx;

  // Head-of-FIFO outputs come straight from storage; valid is simply non-empty.
  assign meta_o  = meta_mem_q[rd_ptr_q];
  assign proto_o = proto_mem_q[rd_ptr_q];
  assign last_o  = last_mem_q[rd_ptr_q];
  assign port_o  = port_mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // Round-robin grant from rr upward; the lock overrides it with the owning port.
  always_comb begin
    full     = (count_q == CntWidth'(FifoDepth));
    pop      = valid_o & ready_i;
    // A full FIFO can still take a word in the same cycle it hands one out.
    can_push = ~rst_i & (~full | ready_i);
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    cand     = '0;
    cidx     = '0;
    // Walk offsets from the far end down so the nearest valid port above rr wins.
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      cand = {1'b0, rr_q} + (PortIdxWidth+1)'(i);
      if (cand >= (PortIdxWidth+1)'(NumPorts)) begin
        cand = cand - (PortIdxWidth+1)'(NumPorts);
      end
      cidx = cand[PortIdxWidth-1:0];
      if (valid_i[cidx]) begin
        gnt_vld = 1'b1;
        gnt_idx = cidx;
      end
    end
`ifdef ETH_IDMA_META_MUX_LOCK_EN
    if (lock_q) begin
      gnt_vld = valid_i[lock_port_q];
      gnt_idx = lock_port_q;
    end
`endif
    push    = gnt_vld & can_push;
    ready_o = '0;
    if (push) begin
      ready_o[gnt_idx] = 1'b1;
    end
    gnt_nxt = (gnt_idx == PortIdxWidth'(NumPorts - 1)) ? '0 : gnt_idx + 1'b1;
  end

  // Next round-robin pointer and packet-lock state after an accepted beat.
  always_comb begin
    rr_d = rr_q;
`ifdef ETH_IDMA_META_MUX_LOCK_EN
    lock_d      = lock_q;
    lock_port_d = lock_port_q;
    if (push) begin
      if (!lock_q) begin
        rr_d = gnt_nxt;
        // An unfinished stream beat pins the grant to its port until last.
        if (proto_i[gnt_idx] && !last_i[gnt_idx]) begin
          lock_d      = 1'b1;
          lock_port_d = gnt_idx;
        end
      end else if (proto_i[gnt_idx] && last_i[gnt_idx]) begin
        // While locked the grant is always lock_port, so gnt_nxt is lock_port+1.
        lock_d = 1'b0;
        rr_d   = gnt_nxt;
      end
    end
`else
    if (push) begin
      rr_d = gnt_nxt;
    end
`endif
  end

  // FIFO write, read and occupancy update.
  always_comb begin
    meta_mem_d  = meta_mem_q;
    port_mem_d  = port_mem_q;
    proto_mem_d = proto_mem_q;
    last_mem_d  = last_mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (push) begin
      meta_mem_d[wr_ptr_q]  = meta_arr[gnt_idx];
      port_mem_d[wr_ptr_q]  = gnt_idx;
      proto_mem_d[wr_ptr_q] = proto_i[gnt_idx];
      last_mem_d[wr_ptr_q]  = last_i[gnt_idx];
      wr_ptr_d              = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO registers; reset clears storage so the head fields read zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FifoDepth; i++) begin
        meta_mem_q[i] <= '0;
        port_mem_q[i] <= '0;
      end
      proto_mem_q <= '0;
      last_mem_q  <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      meta_mem_q  <= meta_mem_d;
      port_mem_q  <= port_mem_d;
      proto_mem_q <= proto_mem_d;
      last_mem_q  <= last_mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
    end
  end

  // Arbiter registers; reset mid-packet drops any lock.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q        <= '0;
`ifdef ETH_IDMA_META_MUX_LOCK_EN
      lock_q      <= 1'b0;
      lock_port_q <= '0;
`endif
    end else begin
      rr_q        <= rr_d;
`ifdef ETH_IDMA_META_MUX_LOCK_EN
      lock_q      <= lock_d;
      lock_port_q <= lock_port_d;
`endif
    end
  end

endmodule
